score_display: RTL and testbench

Converts the binary game score to four decimal digits and drives the `numbers` glyph ROM so the score appears on screen at a fixed position. Sits between the VGA controller (DrawX/DrawY) and the color mapper. It generates `read_address`/`choose_number` for the `numbers` ROM upstream of that ROM, consumes the ROM's registered 1-bit `data_Out`, and emits a pixel-on flag aligned to that ROM's latency.

---
 rtl/score_pkg.sv | 15 +
 rtl/score_display_if.sv | 21 ++
 rtl/bin2bcd_seq.sv | 112 +++++++++++
 rtl/score_display.sv | 104 ++++++++++
 tb/tb_score_display.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/score_pkg.sv
// Shared constants and FSM state type for the score display block.
// Imported by the converter and the render top level.
package score_pkg;

    localparam int DIGIT_W   = 4;
    localparam int GLYPH_DIM = 8;
    localparam int MAX_SCORE = 9999;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } score_state_t;

endpackage

// File: rtl/score_display_if.sv
// Glyph ROM bus between score_display (master) and the numbers ROM (slave).
// Ports: read_address/choose_number to the ROM, rom_data (registered) back.
interface score_display_if;

    logic [18:0] read_address;
    logic [3:0]  choose_number;
    logic        rom_data;

    modport master (
        output read_address,
        output choose_number,
        input  rom_data
    );

    modport slave (
        input  read_address,
        input  choose_number,
        output rom_data
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with a one-deep latest-wins load slot.
// Ports: Clk, Reset, start_i/value_i load, digits_o (BCD), done_o, busy_o.
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int SCORE_W = 14
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      start_i,
    input  logic [SCORE_W-1:0]        value_i,
    output logic [DIGITS*DIGIT_W-1:0] digits_o,
    output logic                      done_o,
    output logic                      busy_o
);

    localparam int BCD_W = DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam logic [CNT_W-1:0]   ITERS = CNT_W'(SCORE_W);
    localparam logic [SCORE_W-1:0] SAT   = SCORE_W'(MAX_SCORE);

    score_state_t       state_q, state_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [SCORE_W-1:0] pval_q, pval_d;

    function automatic logic [SCORE_W-1:0] clamp(input logic [SCORE_W-1:0] v);
        if (32'(v) > 32'(MAX_SCORE)) return SAT;
        return v;
    endfunction

    // One iteration: +3 on nibbles >= 5, then shift {bcd, bin} left.
    function automatic logic [BCD_W+SCORE_W-1:0] dabble(
        input logic [BCD_W-1:0]   b,
        input logic [SCORE_W-1:0] n
    );
        logic [BCD_W-1:0] a;
        a = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[i*DIGIT_W +: DIGIT_W] >= DIGIT_W'(5))
                a[i*DIGIT_W +: DIGIT_W] = a[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(3);
        end
        return {a, n} << 1;
    endfunction

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        pval_d  = pval_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    bin_d   = clamp(value_i);
                    bcd_d   = '0;
                    cnt_d   = ITERS;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, bin_d} = dabble(bcd_q, bin_q);
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = COMMIT;
                if (start_i) begin
                    pend_d = 1'b1;
                    pval_d = value_i;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                // A load in this very cycle supersedes the parked one and is
                // consumed at once, so busy has no gap.
                if (start_i || pend_q) begin
                    bin_d   = clamp(start_i ? value_i : pval_q);
                    bcd_d   = '0;
                    cnt_d   = ITERS;
                    pend_d  = 1'b0;
                    state_d = CONVERT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            pval_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pval_q  <= pval_d;
        end
    end

    assign digits_o = bcd_q;
    assign done_o   = (state_q == COMMIT);
    assign busy_o   = (state_q != IDLE);

endmodule

// File: rtl/score_display.sv
// Score-to-glyph renderer: BCD conversion plus a 3-stage ROM render path.
// Ports: Clk, Reset, score_in/score_load, DrawX/DrawY, rom bus, pixel_on, busy.
module score_display
    import score_pkg::*;
#(
    parameter int         DIGITS  = 4,
    parameter int         SCORE_W = 14,
    parameter logic [9:0] X0      = 10'd480,
    parameter logic [9:0] Y0      = 10'd16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               score_load,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    score_display_if.master    rom,
    output logic               pixel_on,
    output logic               busy
);

    localparam int BCD_W = DIGITS * DIGIT_W;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DX_W  = 3 + IDX_W;
    localparam logic [10:0] X_END = {1'b0, X0} + 11'(GLYPH_DIM * DIGITS);
    localparam logic [10:0] Y_END = {1'b0, Y0} + 11'(GLYPH_DIM);

    logic [BCD_W-1:0]   bcd;
    logic               done;
    logic [BCD_W-1:0]   disp_q, disp_d;
    logic [DX_W-1:0]    dx;
    logic [2:0]         dy;
    logic               in_box;
    logic [IDX_W-1:0]   idx;
    logic [DIGIT_W-1:0] sel;
    logic               blank;
    logic               zero_run;
    logic [5:0]         rc_q, rc_d;
    logic [DIGIT_W-1:0] num_q, num_d;
    logic               vis1_q, vis1_d;
    logic               vis2_q;

    bin2bcd_seq #(
        .DIGITS  (DIGITS),
        .SCORE_W (SCORE_W)
    ) u_conv (
        .Clk      (Clk),
        .Reset    (Reset),
        .start_i  (score_load),
        .value_i  (score_in),
        .digits_o (bcd),
        .done_o   (done),
        .busy_o   (busy)
    );

    // Whole word copied in one cycle: no partially converted digits on screen.
    assign disp_d = done ? bcd : disp_q;

    // S0: only low offset bits matter, so subtract in that narrow width.
    always_comb begin
        dx = DrawX[DX_W-1:0] - X0[DX_W-1:0];
        dy = DrawY[2:0] - Y0[2:0];
        in_box = ({1'b0, DrawX} >= {1'b0, X0}) && ({1'b0, DrawX} < X_END)
              && ({1'b0, DrawY} >= {1'b0, Y0}) && ({1'b0, DrawY} < Y_END);
        idx      = dx[DX_W-1:3];
        sel      = '0;
        blank    = 1'b0;
        zero_run = 1'b1;
        // Digit 0 is most significant; blank while all digits so far are 0.
        for (int i = 0; i < DIGITS; i++) begin
            zero_run = zero_run
                    && (disp_q[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] == '0);
            if (idx == IDX_W'(i)) begin
                sel   = disp_q[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
                blank = zero_run && (i < DIGITS - 1);
            end
        end
        rc_d   = in_box ? {dy, dx[2:0]} : rc_q;
        num_d  = in_box ? sel : num_q;
        vis1_d = in_box && !blank;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            disp_q <= '0;
            rc_q   <= '0;
            num_q  <= '0;
            vis1_q <= 1'b0;
            vis2_q <= 1'b0;
        end else begin
            disp_q <= disp_d;
            rc_q   <= rc_d;
            num_q  <= num_d;
            vis1_q <= vis1_d;
            vis2_q <= vis1_q;
        end
    end

    assign rom.read_address  = 19'(rc_q);
    assign rom.choose_number = num_q;
    // ROM output is registered, so its data lines up with vis2_q.
    assign pixel_on = vis2_q & rom.rom_data;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display with a cycle-level reference model.
// Drives loads, pixel scan positions and ROM data; checks every cycle.
module tb_score_display;

    localparam int DIGITS  = 4;
    localparam int SCORE_W = 14;
    localparam int X0      = 480;
    localparam int Y0      = 16;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [13:0] score_in = '0;
    logic        score_load = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        rom_bit = 1'b0;
    logic        pixel_on;
    logic        busy;

    score_display_if rom_if ();
    assign rom_if.rom_data = rom_bit;

    always #5 Clk = ~Clk;

    score_display #(
        .DIGITS  (DIGITS),
        .SCORE_W (SCORE_W),
        .X0      (10'd480),
        .Y0      (10'd16)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .score_in   (score_in),
        .score_load (score_load),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .rom        (rom_if.master),
        .pixel_on   (pixel_on),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    bit act;
    int conv_val;
    int conv_end;
    bit pend;
    int pend_val;
    int disp;
    int exp_addr;
    int exp_num;
    bit h1, h2;

    function automatic int p10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic int dig(input int d, input int i);
        return (d / p10(DIGITS - 1 - i)) % 10;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        act = 0; pend = 0; disp = 0;
        exp_addr = 0; exp_num = 0;
        h1 = 0; h2 = 0;
        conv_val = 0; conv_end = 0; pend_val = 0;
    endtask

    // One clock cycle: drive, check this cycle's outputs, advance the model.
    task automatic step(input bit rst, input bit ld, input int val,
                        input int x, input int y, input bit rd);
        bit ib;
        int i;
        Reset      = rst;
        score_load = ld;
        score_in   = val[13:0];
        DrawX      = x[9:0];
        DrawY      = y[9:0];
        rom_bit    = rd;
        #1;
        chk("busy", int'(busy), int'(act));
        chk("read_address", int'(rom_if.read_address), exp_addr);
        chk("choose_number", int'(rom_if.choose_number), exp_num);
        chk("pixel_on", int'(pixel_on), int'(h2 & rd));
        if (rst) begin
            model_reset();
        end else begin
            ib = (x >= X0) && (x < X0 + 8 * DIGITS) && (y >= Y0) && (y < Y0 + 8);
            i = 0;
            if (ib) begin
                i = (x - X0) / 8;
                exp_addr = (y - Y0) * 8 + (x - X0) % 8;
                exp_num = dig(disp, i);
            end
            h2 = h1;
            h1 = ib && !((i < DIGITS - 1) && (disp < p10(DIGITS - 1 - i)));
            if (act && cyc == conv_end) begin
                disp = conv_val;
                if (ld || pend) begin
                    conv_val = sat(ld ? val : pend_val);
                    conv_end = cyc + SCORE_W + 1;
                    pend = 0;
                end else begin
                    act = 0;
                end
            end else if (act) begin
                if (ld) begin
                    pend = 1;
                    pend_val = val;
                end
            end else if (ld) begin
                act = 1;
                conv_val = sat(val);
                conv_end = cyc + SCORE_W + 1;
            end
        end
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
    endtask

    task automatic sweep(input int y);
        for (int x = 476; x < 516; x++)
            step(0, 0, 0, x, y, 1'($urandom_range(0, 1)));
    endtask

    task automatic load(input int v);
        step(0, 1, v, 0, 0, 1'b0);
    endtask

    bit r, l;
    int v;

    initial begin
        model_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;

        // Reset values visible with Reset released
        idle(2);

        load(1234);
        idle(16);
        step(0, 0, 0, 480, 16, 1'b1);
        step(0, 0, 0, 0, 0, 1'b1);
        sweep(16);
        sweep(19);

        load(16383);
        idle(16);
        sweep(23);

        load(7);
        idle(16);
        for (int x = 478; x < 514; x++) step(0, 0, 0, x, 20, 1'b1);
        sweep(21);

        load(0);
        idle(16);
        sweep(17);

        // Latest-wins: 50, then 60 superseded by 70
        load(50);
        idle(2);
        load(60);
        idle(1);
        load(70);
        for (int k = 0; k < 45; k++)
            step(0, 0, 0, 480 + (k % 32), 18, 1'b1);

        // Load landing exactly on the commit cycle
        load(5);
        idle(14);
        load(9);
        for (int k = 0; k < 20; k++)
            step(0, 0, 0, 504 + (k % 8), 16 + (k % 8), 1'b1);

        // Field edges with ROM data forced high
        step(0, 0, 0, 479, 16, 1'b1);
        step(0, 0, 0, 512, 16, 1'b1);
        step(0, 0, 0, 480, 15, 1'b1);
        step(0, 0, 0, 480, 24, 1'b1);
        step(0, 0, 0, 487, 23, 1'b1);
        idle(3);

        // Reset in the 5th convert cycle, then a clean conversion
        load(123);
        idle(4);
        step(1, 0, 0, 0, 0, 1'b0);
        idle(2);
        load(42);
        idle(16);
        sweep(22);

        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 499) == 0);
            l = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 99);
            else v = $urandom_range(0, 16383);
            step(r, l, v, $urandom_range(470, 520), $urandom_range(10, 30),
                 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
